// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: opcodes, access-size codes,
// FSM state type and small decode helpers used by lsu_stage and lsu_align.
package lsu_stage_pkg;

    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_LANES  = LSU_DATA_W / 8;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Access width from func3; any code that is not byte or half acts as a word.
    function automatic lsu_size_t lsu_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // Half accesses need an even offset, word accesses a zero offset.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (lsu_size(f3))
            SZ_H:    return off[0];
            SZ_W:    return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_align.sv
// lsu_align: purely combinational byte-lane steering. Produces store write
// mask/data from func3 and the address offset, and shifts/extends a read word
// into the load result.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [2:0]            func3_i,
    input  logic [1:0]            off_i,
    input  logic [LSU_DATA_W-1:0] rs2_i,
    input  logic [LSU_DATA_W-1:0] rdata_i,
    output logic [LSU_LANES-1:0]  wmask_o,
    output logic [LSU_DATA_W-1:0] wdata_o,
    output logic [LSU_DATA_W-1:0] ldata_o
);

    logic [LSU_DATA_W-1:0] shifted;
    logic                  sext;

    // Store side: replicate data to every lane, select lanes with the mask.
    always_comb begin
        wmask_o = '0;
        wdata_o = '0;
        case (lsu_size(func3_i))
            SZ_B: begin
                wmask_o = 4'(4'b0001 << off_i);
                wdata_o = {4{rs2_i[7:0]}};
            end
            SZ_H: begin
                wmask_o = 4'(4'b0011 << {off_i[1], 1'b0});
                wdata_o = {2{rs2_i[15:0]}};
            end
            default: begin
                wmask_o = 4'b1111;
                wdata_o = rs2_i;
            end
        endcase
    end

    // Load side: bring the addressed byte to lane 0, then extend.
    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        sext    = ~func3_i[2];
        ldata_o = shifted;
        case (lsu_size(func3_i))
            SZ_B:    ldata_o = {{24{shifted[7] & sext}}, shifted[7:0]};
            SZ_H:    ldata_o = {{16{shifted[15] & sext}}, shifted[15:0]};
            default: ldata_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: multicycle load/store stage after execute. Runs one valid/ready
// memory transaction per load/store and hands a single result to write-back;
// other instructions pass straight through.
// Optional macro LSU_MISALIGN_TRAP_EN: adds a misalign output and completes
// misaligned loads/stores without a memory request, returning the address.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] exu_res,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    lsu_state_t        state_q;
    logic              in_ready_q;
    logic              mem_req_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wmask_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [2:0]        func3_q;
    logic [1:0]        off_q;
    logic              is_load_q;

    logic              is_load_c;
    logic              is_store_c;
    logic              trap_c;
    logic [2:0]        al_func3_c;
    logic [1:0]        al_off_c;
    logic [3:0]        al_wmask_c;
    logic [DATA_W-1:0] al_wdata_c;
    logic [DATA_W-1:0] al_ldata_c;

    assign is_load_c  = (opcode == OPCODE_LOAD);
    assign is_store_c = (opcode == OPCODE_STORE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap_c   = (is_load_c | is_store_c) & lsu_misaligned(func3, exu_res[1:0]);
    assign misalign = misalign_q;
`else
    assign trap_c   = 1'b0;
`endif

    // Aligner sees the incoming instruction while idle (store setup) and the
    // latched one afterwards (load extraction).
    assign al_func3_c = (state_q == IDLE) ? func3 : func3_q;
    assign al_off_c   = (state_q == IDLE) ? exu_res[1:0] : off_q;

    lsu_align u_align (
        .func3_i (al_func3_c),
        .off_i   (al_off_c),
        .rs2_i   (rs2_data),
        .rdata_i (mem_rdata),
        .wmask_o (al_wmask_c),
        .wdata_o (al_wdata_c),
        .ldata_o (al_ldata_c)
    );

    // Stage FSM with all outputs held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            in_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            func3_q         <= '0;
            off_q           <= '0;
            is_load_q       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        func3_q    <= func3;
                        off_q      <= exu_res[1:0];
                        is_load_q  <= is_load_c;
                        if ((is_load_c || is_store_c) && !trap_c) begin
                            state_q         <= REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= is_store_c;
                            mem_addr_q      <= {exu_res[ADDR_W-1:2], 2'b00};
                            mem_wdata_q     <= is_store_c ? al_wdata_c : '0;
                            mem_wmask_q     <= is_store_c ? al_wmask_c : 4'b0000;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= exu_res;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign_q  <= trap_c;
`endif
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        out_data_q  <= is_load_q ? al_ldata_c : '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_q  <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;

endmodule
